// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared types for the vscale memory arbiter: FSM states, fetch size code and
// the request bundle issued to the backing memory.
package vscale_mem_arb_pkg;

   localparam int ARB_XPR_LEN        = 32;
   localparam int ARB_MEM_TYPE_WIDTH = 3;

   localparam logic [ARB_MEM_TYPE_WIDTH-1:0] MEM_TYPE_WORD = 3'd2;

   typedef enum logic [2:0] {
      DONE,
      D_REQ,
      D_RESP,
      I_REQ,
      I_RESP
   } arb_state_e;

   typedef struct packed {
      logic                          wen;
      logic [ARB_MEM_TYPE_WIDTH-1:0] size;
      logic [ARB_XPR_LEN-1:0]        addr;
      logic [ARB_XPR_LEN-1:0]        wdata;
   } mem_req_t;

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Pipeline-side instruction/data ports plus the backing-memory request/response
// channel. The arbiter uses the slave view; the pipeline/memory side the master view.
interface vscale_mem_arbiter_if
   import vscale_mem_arb_pkg::*;
#(
   parameter int XPR_LEN        = ARB_XPR_LEN,
   parameter int MEM_TYPE_WIDTH = ARB_MEM_TYPE_WIDTH
);
   logic [XPR_LEN-1:0]        imem_addr;
   logic [XPR_LEN-1:0]        imem_rdata;
   logic                      imem_wait;
   logic                      imem_badmem_e;
   logic                      dmem_en;
   logic                      dmem_wen;
   logic [MEM_TYPE_WIDTH-1:0] dmem_size;
   logic [XPR_LEN-1:0]        dmem_addr;
   logic [XPR_LEN-1:0]        dmem_wdata_delayed;
   logic [XPR_LEN-1:0]        dmem_rdata;
   logic                      dmem_wait;
   logic                      dmem_badmem_e;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic                      mem_req_wen;
   logic [MEM_TYPE_WIDTH-1:0] mem_req_size;
   logic [XPR_LEN-1:0]        mem_req_addr;
   logic [XPR_LEN-1:0]        mem_req_wdata;
   logic                      mem_resp_valid;
   logic [XPR_LEN-1:0]        mem_resp_rdata;
   logic                      mem_resp_badmem;

   modport slave (
      input  imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_badmem,
      output imem_rdata, imem_wait, imem_badmem_e,
      output dmem_rdata, dmem_wait, dmem_badmem_e,
      output mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
   );

   modport master (
      output imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_badmem,
      input  imem_rdata, imem_wait, imem_badmem_e,
      input  dmem_rdata, dmem_wait, dmem_badmem_e,
      input  mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
   );

endinterface

// File: rtl/vscale_mem_arbiter.sv
// Serialises the pipeline's fetch and data transactions onto one single-outstanding
// memory port; both pipeline ports stall until every transaction of the group is done.
module vscale_mem_arbiter
   import vscale_mem_arb_pkg::*;
#(
   parameter int XPR_LEN        = ARB_XPR_LEN,
   parameter int MEM_TYPE_WIDTH = ARB_MEM_TYPE_WIDTH,
   parameter bit DMEM_FIRST     = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   vscale_mem_arbiter_if.slave bus
);

   arb_state_e state, state_nxt;
   logic       pend_i, pend_d, pend_i_nxt, pend_d_nxt;
   logic       cap_i, cap_d;
   logic       vld_p1;

   logic [XPR_LEN-1:0]        i_addr_p1;
   logic                      d_wen_p1;
   logic [MEM_TYPE_WIDTH-1:0] d_size_p1;
   logic [XPR_LEN-1:0]        d_addr_p1;
   logic [XPR_LEN-1:0]        d_wdata_p2;
   logic [XPR_LEN-1:0]        d_wdata;

   logic [XPR_LEN-1:0] imem_rdata_q, dmem_rdata_q;
   logic               imem_badmem_q, dmem_badmem_q;

   mem_req_t i_req, d_req, req;

   function automatic mem_req_t sel_req(input logic use_d, input mem_req_t ireq,
                                        input mem_req_t dreq);
      return use_d ? dreq : ireq;
   endfunction

   // control: state, pending flags, address-phase marker
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= DONE;
         pend_i <= 1'b0;
         pend_d <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         pend_i <= pend_i_nxt;
         pend_d <= pend_d_nxt;
         vld_p1 <= (state == DONE);
      end
   end

   always_comb begin
      state_nxt         = state;
      pend_i_nxt        = pend_i;
      pend_d_nxt        = pend_d;
      cap_i             = 1'b0;
      cap_d             = 1'b0;
      bus.mem_req_valid = 1'b0;
      case (state)
         DONE: begin
            pend_i_nxt = 1'b1;
            pend_d_nxt = bus.dmem_en;
            state_nxt  = (bus.dmem_en && DMEM_FIRST) ? D_REQ : I_REQ;
         end
         D_REQ: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) state_nxt = D_RESP;
         end
         D_RESP: begin
            if (bus.mem_resp_valid) begin
               cap_d      = 1'b1;
               pend_d_nxt = 1'b0;
               state_nxt  = pend_i ? I_REQ : DONE;
            end
         end
         I_REQ: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) state_nxt = I_RESP;
         end
         I_RESP: begin
            if (bus.mem_resp_valid) begin
               cap_i      = 1'b1;
               pend_i_nxt = 1'b0;
               state_nxt  = pend_d ? D_REQ : DONE;
            end
         end
         default: state_nxt = DONE;
      endcase
   end

   // p1: address phase capture; p2: store data held from the following cycle
   always_ff @(posedge clk) begin
      if (state == DONE) begin
         i_addr_p1 <= bus.imem_addr;
         d_wen_p1  <= bus.dmem_wen;
         d_size_p1 <= bus.dmem_size;
         d_addr_p1 <= bus.dmem_addr;
      end
      if (vld_p1) d_wdata_p2 <= d_wdata;
   end

   // Store data is live on the bus only in the cycle after the address phase.
   assign d_wdata = vld_p1 ? (d_wen_p1 ? bus.dmem_wdata_delayed : '0) : d_wdata_p2;

   assign i_req = '{wen: 1'b0, size: MEM_TYPE_WORD, addr: i_addr_p1, wdata: '0};
   assign d_req = '{wen: d_wen_p1, size: d_size_p1, addr: d_addr_p1, wdata: d_wdata};
   assign req   = sel_req(state == D_REQ, i_req, d_req);

   assign bus.mem_req_wen   = req.wen;
   assign bus.mem_req_size  = req.size;
   assign bus.mem_req_addr  = req.addr;
   assign bus.mem_req_wdata = req.wdata;

   // response capture into the per-port result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_rdata_q  <= '0;
         imem_badmem_q <= 1'b0;
         dmem_rdata_q  <= '0;
         dmem_badmem_q <= 1'b0;
      end else begin
         if (cap_i) begin
            imem_rdata_q  <= bus.mem_resp_rdata;
            imem_badmem_q <= bus.mem_resp_badmem;
         end
         if (cap_d) begin
            dmem_rdata_q  <= d_wen_p1 ? '0 : bus.mem_resp_rdata;
            dmem_badmem_q <= bus.mem_resp_badmem;
         end
      end
   end

   assign bus.imem_wait     = (state != DONE);
   assign bus.dmem_wait     = (state != DONE);
   assign bus.imem_rdata    = imem_rdata_q;
   assign bus.imem_badmem_e = imem_badmem_q;
   assign bus.dmem_rdata    = dmem_rdata_q;
   assign bus.dmem_badmem_e = dmem_badmem_q;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: a transaction-level model plus a small
// backing memory, checked every cycle, with literal expectations per scenario.
module tb_vscale_mem_arbiter;
   import vscale_mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vscale_mem_arbiter_if bus ();

   vscale_mem_arbiter #(.DMEM_FIRST(1'b1)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- backing memory ----------------
   logic [31:0] mem [logic [31:0]];
   int          resp_delay = 1;
   int          stall_left = 0;
   logic [31:0] bad_addr   = 32'hFFFF_FFFF;
   bit          mp_pend    = 1'b0;
   int          mp_cnt     = 0;
   logic [31:0] mp_rdata   = 32'h0;
   logic        mp_bad     = 1'b0;
   logic        nxt_ready  = 1'b1;
   logic        nxt_rvalid = 1'b0;
   logic [31:0] hs_q[$];
   logic [31:0] last_store = 32'h0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   initial begin
      bus.mem_req_ready   = 1'b1;
      bus.mem_resp_valid  = 1'b0;
      bus.mem_resp_rdata  = 32'h0;
      bus.mem_resp_badmem = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_req_ready   = nxt_ready;
         bus.mem_resp_valid  = nxt_rvalid;
         bus.mem_resp_rdata  = nxt_rvalid ? mp_rdata : 32'h0;
         bus.mem_resp_badmem = nxt_rvalid ? mp_bad : 1'b0;
      end
   end

   // ---------------- transaction-level model ----------------
   bit       m_busy = 1'b0, m_out = 1'b0, m_first = 1'b0;
   int       m_total = 0, m_issued = 0, m_didx = 0;
   mem_req_t m_req[2];
   bit       m_isd[2];
   logic [31:0] m_irdata = 32'h0, m_drdata = 32'h0;
   logic        m_ibad = 1'b0, m_dbad = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        prev_wen = 1'b0;
   logic [2:0]  prev_size = 3'h0;

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         begin
            bit exp_valid;
            int k;
            if (m_busy && m_first) begin
               if (m_isd[m_didx])
                  m_req[m_didx].wdata = m_req[m_didx].wen ? bus.dmem_wdata_delayed : 32'h0;
               m_first = 1'b0;
            end
            exp_valid = m_busy && !m_out && (m_issued < m_total);
            chk("imem_wait", 32'(bus.imem_wait), 32'(m_busy));
            chk("dmem_wait", 32'(bus.dmem_wait), 32'(m_busy));
            chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_valid));
            if (exp_valid) begin
               chk("req_addr", bus.mem_req_addr, m_req[m_issued].addr);
               chk("req_wen", 32'(bus.mem_req_wen), 32'(m_req[m_issued].wen));
               chk("req_size", 32'(bus.mem_req_size), 32'(m_req[m_issued].size));
               chk("req_wdata", bus.mem_req_wdata, m_req[m_issued].wdata);
            end
            if (prev_stall && bus.mem_req_valid) begin
               chk("stall_addr", bus.mem_req_addr, prev_addr);
               chk("stall_wen", 32'(bus.mem_req_wen), 32'(prev_wen));
               chk("stall_size", 32'(bus.mem_req_size), 32'(prev_size));
            end
            if (!m_busy) begin
               chk("imem_rdata", bus.imem_rdata, m_irdata);
               chk("imem_badmem", 32'(bus.imem_badmem_e), 32'(m_ibad));
               chk("dmem_rdata", bus.dmem_rdata, m_drdata);
               chk("dmem_badmem", 32'(bus.dmem_badmem_e), 32'(m_dbad));
            end
            prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
            prev_addr  = bus.mem_req_addr;
            prev_wen   = bus.mem_req_wen;
            prev_size  = bus.mem_req_size;

            // model update for the coming edge
            if (reset) begin
               m_busy = 1'b0; m_out = 1'b0; m_first = 1'b0;
               m_issued = 0; m_total = 0;
               m_irdata = 32'h0; m_drdata = 32'h0; m_ibad = 1'b0; m_dbad = 1'b0;
            end else if (!m_busy) begin
               mem_req_t ir, dr;
               ir = '{wen: 1'b0, size: 3'd2, addr: bus.imem_addr, wdata: 32'h0};
               dr = '{wen: bus.dmem_wen, size: bus.dmem_size, addr: bus.dmem_addr, wdata: 32'h0};
               if (bus.dmem_en) begin
                  m_req[0] = dr; m_isd[0] = 1'b1;
                  m_req[1] = ir; m_isd[1] = 1'b0;
                  m_total = 2;
               end else begin
                  m_req[0] = ir; m_isd[0] = 1'b0;
                  m_total = 1;
               end
               m_didx = 0; m_issued = 0; m_out = 1'b0; m_first = 1'b1; m_busy = 1'b1;
            end else if (m_out && bus.mem_resp_valid) begin
               k = m_issued - 1;
               if (m_isd[k]) begin
                  m_drdata = m_req[k].wen ? 32'h0 : bus.mem_resp_rdata;
                  m_dbad   = bus.mem_resp_badmem;
               end else begin
                  m_irdata = bus.mem_resp_rdata;
                  m_ibad   = bus.mem_resp_badmem;
               end
               m_out = 1'b0;
               if (m_issued == m_total) m_busy = 1'b0;
            end else if (exp_valid && bus.mem_req_ready) begin
               m_out = 1'b1;
               m_issued++;
            end

            // memory update for the coming cycle
            if (bus.mem_resp_valid) mp_pend = 1'b0;
            else if (mp_pend) mp_cnt--;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               hs_q.push_back(bus.mem_req_addr);
               mp_rdata = mem_rd(bus.mem_req_addr);
               mp_bad   = (bus.mem_req_addr == bad_addr);
               if (bus.mem_req_wen) begin
                  mem[bus.mem_req_addr] = bus.mem_req_wdata;
                  last_store = bus.mem_req_wdata;
               end
               mp_pend = 1'b1;
               mp_cnt  = resp_delay;
            end
            if (stall_left > 0) stall_left--;
            nxt_ready  = (stall_left == 0);
            nxt_rvalid = mp_pend && (mp_cnt == 1);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic run_group(input logic [31:0] ia, input logic den, input logic dwen,
                            input logic [31:0] da, input logic [31:0] dwd, output int ncyc);
      int guard = 0;
      while (bus.imem_wait && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      bus.imem_addr          = ia;
      bus.dmem_en            = den;
      bus.dmem_wen           = dwen;
      bus.dmem_size          = 3'd2;
      bus.dmem_addr          = da;
      bus.dmem_wdata_delayed = 32'h0BAD_0BAD;
      ncyc = 0;
      do begin
         @(posedge clk); #1; ncyc++;
         bus.dmem_wdata_delayed = (ncyc == 1) ? dwd : 32'h0;
      end while (bus.imem_wait && ncyc < 100);
      if (ncyc >= 100) begin
         total++; bad++;
         $display("FAIL group_timeout: waits still high after %0d cycles", ncyc);
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      bus.imem_addr = 32'h0; bus.dmem_en = 1'b0; bus.dmem_wen = 1'b0;
      bus.dmem_size = 3'd0; bus.dmem_addr = 32'h0; bus.dmem_wdata_delayed = 32'h0;
      mem[32'h200]  = 32'h13;
      mem[32'h1004] = 32'hCAFE_F00D;
      mem[32'h3000] = 32'h7777_0001;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_imem_wait", 32'(bus.imem_wait), 32'h0);
      chk("rst_dmem_wait", 32'(bus.dmem_wait), 32'h0);
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
      chk("rst_imem_rdata", bus.imem_rdata, 32'h0);
      chk("rst_dmem_rdata", bus.dmem_rdata, 32'h0);
      chk("rst_badmem", 32'({bus.imem_badmem_e, bus.dmem_badmem_e}), 32'h0);
      reset = 1'b0;

      // fetch only
      run_group(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, n);
      chk("fetch_latency", 32'(n), 32'd3);
      chk("fetch_rdata", bus.imem_rdata, 32'h13);

      // load: data first, then fetch
      hs_q.delete();
      run_group(32'h204, 1'b1, 1'b0, 32'h1004, 32'h0, n);
      chk("load_latency", 32'(n), 32'd5);
      chk("load_order_n", 32'(hs_q.size()), 32'd2);
      if (hs_q.size() == 2) begin
         chk("load_order_0", hs_q[0], 32'h1004);
         chk("load_order_1", hs_q[1], 32'h204);
      end
      chk("load_rdata", bus.dmem_rdata, 32'hCAFE_F00D);
      chk("load_irdata", bus.imem_rdata, 32'h5A5A_0204);

      // store with delayed data
      run_group(32'h208, 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, n);
      chk("store_latency", 32'(n), 32'd5);
      chk("store_wdata", last_store, 32'hDEAD_BEEF);
      chk("store_mem", mem_rd(32'h2000), 32'hDEAD_BEEF);
      chk("store_rdata", bus.dmem_rdata, 32'h0);

      // ready held low for four cycles
      stall_left = 5;
      run_group(32'h20C, 1'b1, 1'b0, 32'h1008, 32'h0, n);
      chk("stall_latency", 32'(n), 32'd9);
      chk("stall_rdata", bus.dmem_rdata, 32'h5A5A_1008);

      // data access fault, fetch still completes
      bad_addr = 32'h1010;
      run_group(32'h210, 1'b1, 1'b0, 32'h1010, 32'h0, n);
      chk("bad_latency", 32'(n), 32'd5);
      chk("bad_dmem", 32'(bus.dmem_badmem_e), 32'h1);
      chk("bad_imem", 32'(bus.imem_badmem_e), 32'h0);
      chk("bad_irdata", bus.imem_rdata, 32'h5A5A_0210);

      // fetch-only group leaves data results untouched
      bad_addr = 32'h214;
      run_group(32'h214, 1'b0, 1'b0, 32'h0, 32'h0, n);
      chk("keep_drdata", bus.dmem_rdata, 32'h5A5A_1010);
      chk("keep_dbad", 32'(bus.dmem_badmem_e), 32'h1);
      chk("ifault_bad", 32'(bus.imem_badmem_e), 32'h1);
      bad_addr = 32'hFFFF_FFFF;

      // reset during D_RESP, response lands in the following DONE cycle
      resp_delay = 2;
      bus.imem_addr = 32'h218; bus.dmem_en = 1'b1; bus.dmem_wen = 1'b0;
      bus.dmem_addr = 32'h3000;
      @(posedge clk); #1;
      chk("mid_dreq_valid", 32'(bus.mem_req_valid), 32'h1);
      @(posedge clk); #1;
      chk("mid_dresp_wait", 32'(bus.dmem_wait), 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      resp_delay = 1;
      bus.imem_addr = 32'h200; bus.dmem_en = 1'b0;
      chk("post_rst_iwait", 32'(bus.imem_wait), 32'h0);
      chk("post_rst_dwait", 32'(bus.dmem_wait), 32'h0);
      chk("post_rst_valid", 32'(bus.mem_req_valid), 32'h0);
      chk("post_rst_drdata", bus.dmem_rdata, 32'h0);
      chk("post_rst_irdata", bus.imem_rdata, 32'h0);
      run_group(32'h200, 1'b0, 1'b0, 32'h0, 32'h0, n);
      chk("late_latency", 32'(n), 32'd3);
      chk("late_irdata", bus.imem_rdata, 32'h13);
      chk("late_drdata", bus.dmem_rdata, 32'h0);
      chk("late_dbad", 32'(bus.dmem_badmem_e), 32'h0);

      repeat (10) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
